// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: counters, sync/DE/strobe outputs, scaled coordinates
// and gated colour, all registered outputs one enabled cycle behind the count they describe.
module vga_timing_gen #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int H_SYNC_POL  = 0,
    parameter int V_SYNC_POL  = 0,
    parameter int SCALE_SHIFT = 2,
    parameter int COLOR_W     = 4,
    parameter int CNT_W       = 10
) (
    input  logic               SynchClock,
    input  logic               Reset,
    input  logic               PixEn,
    input  logic               PixelOn,
    input  logic [COLOR_W-1:0] RedIn,
    input  logic [COLOR_W-1:0] GreenIn,
    input  logic [COLOR_W-1:0] BlueIn,
    output logic [CNT_W-1:0]   PixelCol,
    output logic [CNT_W-1:0]   PixelRow,
    output logic [COLOR_W-1:0] Red,
    output logic [COLOR_W-1:0] Green,
    output logic [COLOR_W-1:0] Blue,
    output logic               Hsynch,
    output logic               Vsynch,
    output logic               De,
    output logic               FrameStart,
    output logic               LineStart
);

    localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic             H_POL      = 1'(H_SYNC_POL);
    localparam logic             V_POL      = 1'(V_SYNC_POL);

    logic [CNT_W-1:0]   hCount_q, hCount_d;
    logic [CNT_W-1:0]   vCount_q, vCount_d;
    logic [COLOR_W-1:0] red_q, green_q, blue_q;
    logic               hsync_q, vsync_q, de_q, frameStart_q, lineStart_q;
    logic               active, hSyncOn, vSyncOn, pixelValid;

    // Vertical count only moves on the edge where the horizontal count wraps.
    always_comb begin
        hCount_d = hCount_q + CNT_W'(1);
        vCount_d = vCount_q;
        if (hCount_q == H_LAST) begin
            hCount_d = '0;
            vCount_d = (vCount_q == V_LAST) ? '0 : vCount_q + CNT_W'(1);
        end
    end

    assign active     = (hCount_q < H_ACT_END) && (vCount_q < V_ACT_END);
    assign hSyncOn    = (hCount_q >= H_SYNC_BEG) && (hCount_q < H_SYNC_END);
    assign vSyncOn    = (vCount_q >= V_SYNC_BEG) && (vCount_q < V_SYNC_END);
    assign pixelValid = active && PixelOn;

    assign PixelCol = active ? (hCount_q >> SCALE_SHIFT) : '0;
    assign PixelRow = active ? (vCount_q >> SCALE_SHIFT) : '0;

    always_ff @(posedge SynchClock) begin
        if (!Reset) begin
            hCount_q     <= '0;
            vCount_q     <= '0;
            red_q        <= '0;
            green_q      <= '0;
            blue_q       <= '0;
            hsync_q      <= ~H_POL;
            vsync_q      <= ~V_POL;
            de_q         <= 1'b0;
            frameStart_q <= 1'b0;
            lineStart_q  <= 1'b0;
        end else if (PixEn) begin
            hCount_q     <= hCount_d;
            vCount_q     <= vCount_d;
            red_q        <= pixelValid ? RedIn   : '0;
            green_q      <= pixelValid ? GreenIn : '0;
            blue_q       <= pixelValid ? BlueIn  : '0;
            hsync_q      <= hSyncOn ? H_POL : ~H_POL;
            vsync_q      <= vSyncOn ? V_POL : ~V_POL;
            de_q         <= active;
            frameStart_q <= (hCount_q == '0) && (vCount_q == '0);
            lineStart_q  <= (hCount_q == '0);
        end
    end

    assign Red        = red_q;
    assign Green      = green_q;
    assign Blue       = blue_q;
    assign Hsynch     = hsync_q;
    assign Vsynch     = vsync_q;
    assign De         = de_q;
    assign FrameStart = frameStart_q;
    assign LineStart  = lineStart_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen using a small raster so whole frames run quickly;
// a position-based model predicts every output each cycle.
module tb_vga_timing_gen;

    localparam int HA = 16, HFP = 4, HS = 6, HB = 5, HT = HA + HFP + HS + HB;
    localparam int VA = 10, VFP = 2, VS = 3, VB = 4, VT = VA + VFP + VS + VB;
    localparam bit HPOL = 1'b1, VPOL = 1'b0;
    localparam int SH = 1, CW = 4, NW = 6;

    logic          SynchClock = 1'b0;
    logic          Reset = 1'b0, PixEn = 1'b0, PixelOn = 1'b0;
    logic [CW-1:0] RedIn = '0, GreenIn = '0, BlueIn = '0;
    logic [NW-1:0] PixelCol, PixelRow;
    logic [CW-1:0] Red, Green, Blue;
    logic          Hsynch, Vsynch, De, FrameStart, LineStart;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB),
        .H_SYNC_POL(1), .V_SYNC_POL(0), .SCALE_SHIFT(SH), .COLOR_W(CW), .CNT_W(NW)
    ) dut (
        .SynchClock(SynchClock), .Reset(Reset), .PixEn(PixEn), .PixelOn(PixelOn),
        .RedIn(RedIn), .GreenIn(GreenIn), .BlueIn(BlueIn),
        .PixelCol(PixelCol), .PixelRow(PixelRow),
        .Red(Red), .Green(Green), .Blue(Blue),
        .Hsynch(Hsynch), .Vsynch(Vsynch), .De(De),
        .FrameStart(FrameStart), .LineStart(LineStart)
    );

    always #5 SynchClock = ~SynchClock;

    int checks = 0, errors = 0;
    int tick = 0;
    bit modelValid = 1'b0;
    logic          eDe, eHs, eVs, eFs, eLs;
    logic [CW-1:0] eR, eG, eB;

    function automatic int hOf(input int p); return p % HT; endfunction
    function automatic int vOf(input int p); return (p / HT) % VT; endfunction
    function automatic bit isActive(input int p); return (hOf(p) < HA) && (vOf(p) < VA); endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    // The model tracks only how many enabled edges have passed since reset.
    task automatic applyStimulus(input bit rstN, input bit en, input bit on);
        int  p;
        bit  a;
        RedIn   = CW'($urandom);
        GreenIn = CW'($urandom);
        BlueIn  = CW'($urandom);
        Reset   = rstN;
        PixEn   = en;
        PixelOn = on;
        if (!rstN) begin
            modelValid = 1'b1;
            tick = 0;
            eDe = 0; eFs = 0; eLs = 0; eR = '0; eG = '0; eB = '0;
            eHs = !HPOL; eVs = !VPOL;
        end else if (en) begin
            p   = tick;
            a   = isActive(p);
            eDe = a;
            eR  = (a && on) ? RedIn   : '0;
            eG  = (a && on) ? GreenIn : '0;
            eB  = (a && on) ? BlueIn  : '0;
            eHs = (hOf(p) >= HA + HFP && hOf(p) < HA + HFP + HS) ? HPOL : !HPOL;
            eVs = (vOf(p) >= VA + VFP && vOf(p) < VA + VFP + VS) ? VPOL : !VPOL;
            eFs = (p % (HT * VT)) == 0;
            eLs = hOf(p) == 0;
            tick++;
        end
        @(posedge SynchClock);
        #1;
        if (modelValid) begin
            checkOutput("de", De, eDe);
            checkOutput("hsync", Hsynch, eHs);
            checkOutput("vsync", Vsynch, eVs);
            checkOutput("frame_start", FrameStart, eFs);
            checkOutput("line_start", LineStart, eLs);
            checkOutput("red", Red, eR);
            checkOutput("green", Green, eG);
            checkOutput("blue", Blue, eB);
            checkOutput("pixel_col", PixelCol, isActive(tick) ? (hOf(tick) >> SH) : 0);
            checkOutput("pixel_row", PixelRow, isActive(tick) ? (vOf(tick) >> SH) : 0);
        end
    endtask

    initial begin
        int cyc = 0, lastLs = -1, lastFs = -1, hsWidth = 0;
        int frameVs = 0, frameDe = 0, framesSeen = 0;
        bit prevHs = 1'b0, prevVs = 1'b1, found = 1'b0;

        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("rst_hsync_idle", Hsynch, 0);
        checkOutput("rst_vsync_idle", Vsynch, 1);
        checkOutput("rst_de", De, 0);
        checkOutput("rst_rgb", {Red, Green, Blue}, 0);
        checkOutput("rst_coords", {PixelCol, PixelRow}, 0);

        // Two full frames at full rate with literal period and width measurements.
        for (int i = 0; i < 2 * HT * VT + 40; i++) begin
            applyStimulus(1'b1, 1'b1, 1'($urandom));
            cyc++;
            if (LineStart) begin
                if (lastLs >= 0) checkOutput("line_period", cyc - lastLs, 31);
                lastLs = cyc;
            end
            if (Hsynch && !prevHs) begin
                checkOutput("hsync_offset", cyc - lastLs, 20);
                hsWidth = 0;
            end
            if (Hsynch) hsWidth++;
            if (!Hsynch && prevHs) checkOutput("hsync_width", hsWidth, 6);
            if (FrameStart) begin
                if (lastFs >= 0) begin
                    checkOutput("frame_period", cyc - lastFs, 589);
                    checkOutput("vsync_cycles", frameVs, 93);
                    checkOutput("de_cycles", frameDe, 160);
                end
                lastFs = cyc; frameVs = 0; frameDe = 0; framesSeen++;
            end
            if (!Vsynch && prevVs && lastFs >= 0) checkOutput("vsync_start", cyc - lastFs, 372);
            if (!Vsynch) frameVs++;
            if (De) frameDe++;
            if (!De) checkOutput("blank_rgb_zero", {Red, Green, Blue}, 0);
            prevHs = Hsynch;
            prevVs = Vsynch;
        end
        checkOutput("frames_seen", framesSeen, 3);

        // Clock enable every 4th cycle, then random enables.
        for (int i = 0; i < 4 * HT * VT; i++) applyStimulus(1'b1, (i % 4) == 0, 1'($urandom));
        for (int i = 0; i < 600; i++) applyStimulus(1'b1, 1'($urandom), 1'($urandom));

        // Reset partway into the frame and confirm the restart point.
        for (int i = 0; i < 800 && !found; i++) begin
            if (vOf(tick) == 5) found = 1'b1;
            else applyStimulus(1'b1, 1'b1, 1'b1);
        end
        checkOutput("reach_row5", found, 1);
        checkOutput("row5_scaled", PixelRow, 2);
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("held_after_reset_fs", FrameStart, 0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("restart_fs", FrameStart, 1);
        checkOutput("restart_ls", LineStart, 1);
        checkOutput("restart_de", De, 1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("col9_scaled", PixelCol, 4);
        checkOutput("row0_scaled", PixelRow, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
